// File: rtl/dram_burst_writer.sv
// AXI4 INCR write-burst master. Pixel words and burst commands are buffered in two FIFOs.
// A burst is launched only once its whole payload is already in the data FIFO.
module dram_burst_writer #(
    parameter int DATA_DEPTH = 512,
    parameter int CTRL_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [35:0] data_in,
    input  logic        data_we,
    input  logic [39:0] ctrl_in,
    input  logic        ctrl_we,
    output logic        data_full,
    output logic        ctrl_full,
    output logic        idle,
    output logic [3:0]  err,
    output logic [31:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int CAW = $clog2(CTRL_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t         state_q, state_d;
    logic [35:0]    data_mem [DATA_DEPTH];
    logic [39:0]    ctrl_mem [CTRL_DEPTH];
    logic [DAW-1:0] d_wr_q, d_wr_d, d_rd_q, d_rd_d;
    logic [DAW:0]   d_cnt_q, d_cnt_d;
    logic [CAW-1:0] c_wr_q, c_wr_d, c_rd_q, c_rd_d;
    logic [CAW:0]   c_cnt_q, c_cnt_d;
    logic [31:0]    awaddr_q, awaddr_d;
    logic [7:0]     awlen_q, awlen_d;
    logic [7:0]     beats_q, beats_d;
    logic [3:0]     err_q, err_d;
    logic           d_push, d_pop, c_push, c_pop;
    logic [39:0]    ctrl_head;
    logic [7:0]     head_len;

    assign data_full = (d_cnt_q == (DAW+1)'(DATA_DEPTH));
    assign ctrl_full = (c_cnt_q == (CAW+1)'(CTRL_DEPTH));
    assign ctrl_head = ctrl_mem[c_rd_q];
    assign head_len  = ctrl_head[39:32];

    // Zero-length commands never reach the FIFO, so the FSM can trust every head length.
    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        beats_d  = beats_q;
        err_d    = err_q;
        c_pop    = 1'b0;
        d_pop    = 1'b0;
        d_push   = data_we && !data_full;
        c_push   = ctrl_we && !ctrl_full && (ctrl_in[39:32] != 8'd0);

        if (data_we && data_full) begin
            err_d[0] = 1'b1;
        end
        if (ctrl_we && (ctrl_in[39:32] == 8'd0)) begin
            err_d[2] = 1'b1;
        end else if (ctrl_we && ctrl_full) begin
            err_d[1] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if ((c_cnt_q != '0) && (d_cnt_q >= (DAW+1)'(head_len))) begin
                    c_pop    = 1'b1;
                    awaddr_d = ctrl_head[31:0];
                    awlen_d  = head_len - 8'd1;
                    beats_d  = head_len;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (m_awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_wready) begin
                    d_pop   = 1'b1;
                    beats_d = beats_q - 8'd1;
                    if (beats_q == 8'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        err_d[3] = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        d_wr_d  = d_push ? d_wr_q + DAW'(1) : d_wr_q;
        d_rd_d  = d_pop  ? d_rd_q + DAW'(1) : d_rd_q;
        d_cnt_d = d_cnt_q + (DAW+1)'(d_push) - (DAW+1)'(d_pop);
        c_wr_d  = c_push ? c_wr_q + CAW'(1) : c_wr_q;
        c_rd_d  = c_pop  ? c_rd_q + CAW'(1) : c_rd_q;
        c_cnt_d = c_cnt_q + (CAW+1)'(c_push) - (CAW+1)'(c_pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            d_wr_q   <= '0;
            d_rd_q   <= '0;
            d_cnt_q  <= '0;
            c_wr_q   <= '0;
            c_rd_q   <= '0;
            c_cnt_q  <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            beats_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            d_wr_q   <= d_wr_d;
            d_rd_q   <= d_rd_d;
            d_cnt_q  <= d_cnt_d;
            c_wr_q   <= c_wr_d;
            c_rd_q   <= c_rd_d;
            c_cnt_q  <= c_cnt_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            beats_q  <= beats_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: a flush only moves the pointers.
    always_ff @(posedge CLK) begin
        if (d_push) begin
            data_mem[d_wr_q] <= data_in;
        end
        if (c_push) begin
            ctrl_mem[c_wr_q] <= ctrl_in;
        end
    end

    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = 3'b010;
    assign m_awburst = 2'b01;
    assign m_awvalid = (state_q == ADDR);
    assign m_wvalid  = (state_q == DATA);
    assign m_wlast   = (state_q == DATA) && (beats_q == 8'd1);
    assign m_wdata   = data_mem[d_rd_q][31:0];
    assign m_wstrb   = data_mem[d_rd_q][35:32];
    assign m_bready  = (state_q == RESP);
    assign idle      = (state_q == IDLE) && (d_cnt_q == '0) && (c_cnt_q == '0);
    assign err       = err_q;

endmodule

// File: tb/tb_dram_burst_writer.sv
// Bench for dram_burst_writer: table-driven single bursts, hand-written corner sequences,
// and randomized traffic checked against a queue-based model of the expected AXI stream.
module tb_dram_burst_writer;
    localparam int DD = 512;
    localparam int CD = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [35:0] data_in;
    logic        data_we;
    logic [39:0] ctrl_in;
    logic        ctrl_we;
    logic        data_full, ctrl_full, idle;
    logic [3:0]  err;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;

    always #5 CLK = ~CLK;

    dram_burst_writer #(.DATA_DEPTH(DD), .CTRL_DEPTH(CD)) dut (
        .CLK(CLK), .RST(RST),
        .data_in(data_in), .data_we(data_we), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we),
        .data_full(data_full), .ctrl_full(ctrl_full), .idle(idle), .err(err),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected write-data stream, accepted commands, sticky error bits.
    logic [35:0] exp_data[$];
    logic [39:0] exp_aw[$];
    int          remaining;
    logic [3:0]  exp_err;

    int cyc = 0;
    int beats, aw_count, aw_rise_cyc, aw_hs_cyc, last_ctrl_cyc, last_data_cyc;
    int last_wlast_cyc, first_beat_cyc, last_beat_cyc;
    int gaps[$];

    logic        prev_aw_stall, prev_w_stall, prev_awvalid, prev_wlast;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [35:0] prev_w;
    logic [39:0] mon_aw;
    logic [35:0] mon_w;

    int         aw_delay    = 0;
    int         wready_mode = 0;
    logic [1:0] bresp_cfg   = 2'b00;
    int         aw_stall_cnt;

    typedef struct {
        int          len;
        logic [31:0] addr;
        int          aw_dly;
        int          wmode;
        logic [1:0]  bresp;
        logic [3:0]  exp_err;
        int          exp_aw;
    } vec_t;

    vec_t vecs[7];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI slave: AW ready after a configurable stall, W ready by mode, B answers bready at once.
    initial begin
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        aw_stall_cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (m_awvalid) begin
                m_awready = (aw_stall_cnt >= aw_delay);
                aw_stall_cnt++;
            end else begin
                m_awready = 1'b0;
                aw_stall_cnt = 0;
            end
            case (wready_mode)
                0:       m_wready = 1'b1;
                1:       m_wready = ~m_wready;
                default: m_wready = 1'($urandom % 2);
            endcase
            m_bvalid = m_bready;
            m_bresp  = bresp_cfg;
        end
    end

    // Monitor: compares every handshake against the model and checks hold rules while stalled.
    always @(negedge CLK) begin
        cyc++;
        if (ctrl_we) last_ctrl_cyc = cyc;
        if (data_we) last_data_cyc = cyc;
        if (RST === 1'b0) begin
            if (m_awvalid && !prev_awvalid) begin
                if (aw_rise_cyc < 0) aw_rise_cyc = cyc;
                if (last_wlast_cyc >= 0) gaps.push_back(cyc - last_wlast_cyc);
            end
            if (prev_aw_stall) begin
                check_output("aw_hold_valid", m_awvalid, 1);
                check_output("aw_hold_addr", m_awaddr, prev_awaddr);
                check_output("aw_hold_len", m_awlen, prev_awlen);
            end
            if (prev_w_stall) begin
                check_output("w_hold_valid", m_wvalid, 1);
                check_output("w_hold_payload", {m_wstrb, m_wdata}, prev_w);
                check_output("w_hold_last", m_wlast, prev_wlast);
            end
            if (m_awvalid && m_awready) begin
                aw_count++;
                aw_hs_cyc = cyc;
                if (exp_aw.size() == 0) begin
                    check_output("aw_unexpected", 1, 0);
                end else begin
                    mon_aw = exp_aw.pop_front();
                    check_output("awaddr", m_awaddr, mon_aw[31:0]);
                    check_output("awlen", m_awlen, 8'(mon_aw[39:32] - 8'd1));
                    check_output("awsize_burst", {m_awsize, m_awburst}, 5'b010_01);
                    remaining = int'(mon_aw[39:32]);
                end
            end
            if (m_wvalid && m_wready) begin
                beats++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                if (exp_data.size() == 0) begin
                    check_output("w_unexpected", 1, 0);
                end else begin
                    mon_w = exp_data.pop_front();
                    check_output("wdata", {m_wstrb, m_wdata}, mon_w);
                end
                check_output("wlast", m_wlast, remaining == 1);
                remaining--;
                if (m_wlast) last_wlast_cyc = cyc;
            end
            if (m_bvalid && m_bready && (m_bresp != 2'b00)) exp_err[3] = 1'b1;
            prev_aw_stall = m_awvalid && !m_awready;
            prev_awaddr   = m_awaddr;
            prev_awlen    = m_awlen;
            prev_w_stall  = m_wvalid && !m_wready;
            prev_w        = {m_wstrb, m_wdata};
            prev_wlast    = m_wlast;
            prev_awvalid  = m_awvalid;
        end else begin
            prev_aw_stall = 1'b0;
            prev_w_stall  = 1'b0;
            prev_awvalid  = 1'b0;
        end
    end

    task automatic clear_model();
        exp_data.delete();
        exp_aw.delete();
        gaps.delete();
        remaining      = 0;
        exp_err        = 4'b0000;
        beats          = 0;
        aw_count       = 0;
        aw_rise_cyc    = -1;
        aw_hs_cyc      = -1;
        last_wlast_cyc = -1;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        data_we = 1'b0;
        ctrl_we = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        clear_model();
        RST = 1'b0;
    endtask

    task automatic push_data(input logic [35:0] w);
        @(posedge CLK);
        #1;
        data_in = w;
        data_we = 1'b1;
        ctrl_we = 1'b0;
        if (exp_data.size() < DD) exp_data.push_back(w);
        else exp_err[0] = 1'b1;
    endtask

    task automatic push_ctrl(input logic [7:0] len, input logic [31:0] addr);
        @(posedge CLK);
        #1;
        ctrl_in = {len, addr};
        ctrl_we = 1'b1;
        data_we = 1'b0;
        if (len == 8'd0) exp_err[2] = 1'b1;
        else if (exp_aw.size() >= CD) exp_err[1] = 1'b1;
        else exp_aw.push_back({len, addr});
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            data_we = 1'b0;
            ctrl_we = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (3) @(posedge CLK);
        while (!idle && n < budget) begin
            @(negedge CLK);
            n++;
        end
        #1;
        check_output("idle_reached", idle, 1);
    endtask

    task automatic apply_stimulus(input vec_t v);
        do_reset();
        aw_delay    = v.aw_dly;
        wready_mode = v.wmode;
        bresp_cfg   = v.bresp;
        for (int i = 0; i < v.len; i++) push_data({4'hF ^ 4'(i), 32'(i)});
        push_ctrl(8'(v.len), v.addr);
        quiet(1);
        wait_idle(3000);
        check_output("vec_err", err, v.exp_err);
        check_output("vec_aw_count", aw_count, v.exp_aw);
        check_output("vec_beats", beats, (v.exp_aw > 0) ? v.len : 0);
        if (v.exp_aw > 0) begin
            check_output("cmd_latency", aw_rise_cyc - last_ctrl_cyc, 2);
            if (v.wmode == 0) begin
                check_output("first_beat_after_aw", first_beat_cyc - aw_hs_cyc, 1);
                check_output("burst_cycles", last_beat_cyc - first_beat_cyc + 1, v.len);
            end
        end
    endtask

    initial begin
        int n;
        int total;
        int nc;
        int len;
        logic [31:0] addr;
        vecs[0] = '{64,  32'h0000_1900, 0, 0, 2'b00, 4'b0000, 1};
        vecs[1] = '{1,   32'h0000_0040, 0, 0, 2'b00, 4'b0000, 1};
        vecs[2] = '{255, 32'h0000_2000, 0, 0, 2'b00, 4'b0000, 1};
        vecs[3] = '{64,  32'h0000_4000, 5, 1, 2'b00, 4'b0000, 1};
        vecs[4] = '{0,   32'h0000_5000, 0, 0, 2'b00, 4'b0100, 0};
        vecs[5] = '{16,  32'h0000_6000, 2, 2, 2'b10, 4'b1000, 1};
        vecs[6] = '{3,   32'h0000_7FF0, 0, 0, 2'b11, 4'b1000, 1};

        RST     = 1'b1;
        data_we = 1'b0;
        ctrl_we = 1'b0;
        data_in = '0;
        ctrl_in = '0;
        clear_model();
        repeat (2) @(posedge CLK);
        #1;
        check_output("reset_outputs",
            {m_awvalid, m_wvalid, m_wlast, m_bready, data_full, ctrl_full, idle, err, m_awaddr, m_awlen},
            {6'b0, 1'b1, 44'b0});

        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

        // Command queued before its data: the start is gated by the 64th word.
        do_reset();
        aw_delay = 0; wready_mode = 0; bresp_cfg = 2'b00;
        push_ctrl(8'd64, 32'h0000_0000);
        for (int i = 0; i < 64; i++) push_data({4'hF, 32'hA000_0000 + 32'(i)});
        quiet(1);
        wait_idle(2000);
        check_output("data_gated_start", aw_rise_cyc - last_data_cyc, 2);
        check_output("data_gated_beats", beats, 64);

        // Three queued bursts back to back.
        do_reset();
        for (int i = 0; i < 192; i++) push_data({4'h3, 32'h5500_0000 + 32'(i)});
        for (int k = 0; k < 3; k++) push_ctrl(8'd64, 32'(k * 6400));
        quiet(1);
        wait_idle(3000);
        check_output("b2b_aw_count", aw_count, 3);
        check_output("b2b_beats", beats, 192);
        check_output("b2b_gap_count", gaps.size(), 2);
        foreach (gaps[k]) check_output("b2b_gap_le3", gaps[k] <= 3, 1);
        check_output("b2b_err", err, 4'b0000);

        // Data and command overflow.
        do_reset();
        for (int i = 0; i < DD + 1; i++) push_data({4'h1, 32'(i)});
        quiet(2);
        check_output("data_full", data_full, 1);
        check_output("data_overflow_err", err, exp_err);
        check_output("data_overflow_bit", err, 4'b0001);
        do_reset();
        for (int k = 0; k < CD + 1; k++) push_ctrl(8'd255, 32'(k * 4096));
        quiet(2);
        check_output("ctrl_full", ctrl_full, 1);
        check_output("ctrl_overflow_err", err, 4'b0010);
        check_output("ctrl_overflow_no_aw", aw_count, 0);

        // Reset in the middle of the data phase.
        do_reset();
        for (int i = 0; i < 64; i++) push_data({4'hC, 32'h7700_0000 + 32'(i)});
        push_ctrl(8'd64, 32'h0000_3000);
        quiet(1);
        n = 0;
        while (beats < 20 && n < 500) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check_output("mid_reset_reached_beat20", beats, 20);
        RST = 1'b1;
        #1;
        check_output("mid_reset_wvalid", m_wvalid, 0);
        check_output("mid_reset_idle_empty", idle, 1);
        check_output("mid_reset_data_full", data_full, 0);
        do_reset();
        for (int i = 0; i < 8; i++) push_data({4'h9, 32'hBEEF_0000 + 32'(i)});
        push_ctrl(8'd8, 32'h0000_0800);
        quiet(1);
        wait_idle(500);
        check_output("post_reset_beats", beats, 8);
        check_output("post_reset_err", err, 4'b0000);

        // Randomized traffic against the model.
        do_reset();
        total = 0;
        for (int it = 0; it < 25; it++) begin
            aw_delay    = int'($urandom % 4);
            wready_mode = ($urandom % 2 == 0) ? 0 : 2;
            bresp_cfg   = ($urandom % 8 == 0) ? 2'b10 : 2'b00;
            nc = 1 + int'($urandom % 3);
            for (int c = 0; c < nc; c++) begin
                len  = 1 + int'($urandom % 64);
                addr = 32'(($urandom % 64) * 4096 + ($urandom % 8) * 256);
                total += len;
                if ($urandom % 2 == 0) begin
                    push_ctrl(8'(len), addr);
                    for (int i = 0; i < len; i++) push_data(36'($urandom) ^ {4'(i), 32'($urandom)});
                end else begin
                    for (int i = 0; i < len; i++) push_data(36'($urandom) ^ {4'(i), 32'($urandom)});
                    push_ctrl(8'(len), addr);
                end
                quiet(int'($urandom % 3));
            end
            quiet(1);
            wait_idle(3000);
            check_output("rand_beats", beats, total);
            check_output("rand_err", err, exp_err);
            check_output("rand_model_drained", exp_aw.size() + exp_data.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
